// File: rtl/envelope_pkg.sv
// Shared types and helpers for the per-band envelope follower.
package envelope_pkg;

   typedef enum logic [1:0] {ATTACK, HOLD, RELEASE} env_phase_e;

   localparam logic [31:0] ENV_MAX = 32'h7FFF_FFFF;

   // The most negative sample has no positive twin; clamp it onto the envelope ceiling.
   function automatic logic [31:0] sat_abs(input logic signed [31:0] x);
      logic [31:0] r;
      if (x == 32'sh8000_0000) begin
         r = ENV_MAX;
      end else if (x < 0) begin
         r = 32'(-x);
      end else begin
         r = 32'(x);
      end
      return r;
   endfunction

endpackage

// File: rtl/env_slew.sv
// Moves an envelope one smoothing step toward a target.
// The step is at least 1 and never crosses the target.
module env_slew (
   input  logic [31:0] i_env,
   input  logic [31:0] i_abs,
   input  logic [4:0]  i_shift,
   output logic [31:0] o_env
);

   logic        w_rising;
   logic        w_falling;
   logic [31:0] w_diff;
   logic [31:0] w_shifted;
   logic [31:0] w_step;

   assign w_rising  = i_abs > i_env;
   assign w_falling = i_env > i_abs;
   assign w_diff    = w_rising ? (i_abs - i_env) : (i_env - i_abs);
   assign w_shifted = w_diff >> i_shift;

   // The shifted step is never larger than the difference, so the step cannot
   // overshoot; forcing a minimum of 1 guarantees exact convergence.
   assign w_step = (w_shifted == 32'd0) ? 32'd1 : w_shifted;

   always_comb begin
      o_env = i_env;
      if (w_rising) begin
         o_env = i_env + w_step;
      end else if (w_falling) begin
         o_env = i_env - w_step;
      end
   end

endmodule

// File: rtl/envelope_follower.sv
// Rectifies a band sample stream and tracks it with attack/hold/release
// smoothing, emitting the envelope once every DECIM accepted samples.
module envelope_follower
   import envelope_pkg::*;
#(
   parameter int ATTACK_SHIFT  = 4,
   parameter int RELEASE_SHIFT = 10,
   parameter int HOLD_SAMPLES  = 64,
   parameter int DECIM         = 32
) (
   input  logic        clk_in,
   input  logic        rst_n_in,
   input  logic        valid_in,
   input  logic [31:0] sample_in,
   output logic [31:0] env_out,
   output logic        valid_out
);

   localparam logic [4:0]  LP_ATTACK_SHIFT  = 5'(ATTACK_SHIFT);
   localparam logic [4:0]  LP_RELEASE_SHIFT = 5'(RELEASE_SHIFT);
   localparam logic [15:0] LP_HOLD          = 16'(HOLD_SAMPLES);
   localparam logic [15:0] LP_DEC_LAST      = 16'(DECIM - 1);

   logic [31:0] r_abs;
   logic        r_valid1;

   env_phase_e  r_phase;
   env_phase_e  w_phaseNext;
   logic [31:0] r_env;
   logic [31:0] w_envNext;
   logic [15:0] r_hold;
   logic [15:0] w_holdNext;
   logic [15:0] r_dec;
   logic [15:0] w_decNext;
   logic        w_emit;

   logic [31:0] r_envOut;
   logic        r_validOut;

   logic [31:0] w_attackEnv;
   logic [31:0] w_releaseEnv;

   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         r_abs    <= 32'd0;
         r_valid1 <= 1'b0;
      end else begin
         r_valid1 <= valid_in;
         if (valid_in) begin
            r_abs <= sat_abs(sample_in);
         end
      end
   end

   env_slew u_attack (
      .i_env   (r_env),
      .i_abs   (r_abs),
      .i_shift (LP_ATTACK_SHIFT),
      .o_env   (w_attackEnv)
   );

   env_slew u_release (
      .i_env   (r_env),
      .i_abs   (r_abs),
      .i_shift (LP_RELEASE_SHIFT),
      .o_env   (w_releaseEnv)
   );

   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         r_phase    <= RELEASE;
         r_env      <= 32'd0;
         r_hold     <= 16'd0;
         r_dec      <= 16'd0;
         r_envOut   <= 32'd0;
         r_validOut <= 1'b0;
      end else begin
         r_phase    <= w_phaseNext;
         r_env      <= w_envNext;
         r_hold     <= w_holdNext;
         r_dec      <= w_decNext;
         r_validOut <= w_emit;
         if (w_emit) begin
            r_envOut <= w_envNext;
         end
      end
   end

   // Attack always wins and re-arms the hold; release only starts once the
   // hold count has drained on non-attack samples.
   always_comb begin
      w_phaseNext = r_phase;
      w_envNext   = r_env;
      w_holdNext  = r_hold;
      w_decNext   = r_dec;
      w_emit      = 1'b0;
      if (r_valid1) begin
         if (r_abs > r_env) begin
            w_envNext   = w_attackEnv;
            w_holdNext  = LP_HOLD;
            w_phaseNext = ATTACK;
         end else if (r_hold != 16'd0) begin
            w_holdNext  = r_hold - 16'd1;
            w_phaseNext = HOLD;
         end else if (r_env > r_abs) begin
            w_envNext   = w_releaseEnv;
            w_phaseNext = RELEASE;
         end
         if (r_dec == LP_DEC_LAST) begin
            w_decNext = 16'd0;
            w_emit    = 1'b1;
         end else begin
            w_decNext = r_dec + 16'd1;
         end
      end
   end

   assign env_out   = r_envOut;
   assign valid_out = r_validOut;

endmodule

// File: tb/tb_envelope_follower.sv
// Scoreboard bench: two followers (DECIM=1 and DECIM=4) share one stimulus
// stream and are checked against an arithmetic envelope model.
module tb_envelope_follower;

   localparam int AS    = 2;
   localparam int RS    = 4;
   localparam int HOLDN = 2;
   localparam int DECB  = 4;

   logic        clk_in    = 1'b0;
   logic        rst_n_in  = 1'b0;
   logic        valid_in  = 1'b0;
   logic [31:0] sample_in = 32'd0;
   logic [31:0] envA;
   logic [31:0] envB;
   logic        validA;
   logic        validB;

   always #5 clk_in = ~clk_in;

   envelope_follower #(
      .ATTACK_SHIFT  (AS),
      .RELEASE_SHIFT (RS),
      .HOLD_SAMPLES  (HOLDN),
      .DECIM         (1)
   ) u_dutA (
      .clk_in    (clk_in),
      .rst_n_in  (rst_n_in),
      .valid_in  (valid_in),
      .sample_in (sample_in),
      .env_out   (envA),
      .valid_out (validA)
   );

   envelope_follower #(
      .ATTACK_SHIFT  (AS),
      .RELEASE_SHIFT (RS),
      .HOLD_SAMPLES  (HOLDN),
      .DECIM         (DECB)
   ) u_dutB (
      .clk_in    (clk_in),
      .rst_n_in  (rst_n_in),
      .valid_in  (valid_in),
      .sample_in (sample_in),
      .env_out   (envB),
      .valid_out (validB)
   );

   typedef struct {
      longint env;
      int     due;
   } exp_t;

   exp_t   qA[$];
   exp_t   qB[$];
   exp_t   eA;
   exp_t   eB;
   int     checks   = 0;
   int     failures = 0;
   int     cyc      = 0;
   int     pulsesB  = 0;
   longint mEnv     = 0;
   int     mHold    = 0;
   int     mDecB    = 0;

   always @(posedge clk_in) cyc <= cyc + 1;

   task automatic checkOutput(input string name, input longint act, input longint req);
      checks++;
      if (act != req) begin
         failures++;
         $display("[TB] FAIL %s actual=%0d required=%0d (cycle %0d)", name, act, req, cyc);
      end
   endtask

   function automatic void modelReset();
      mEnv  = 0;
      mHold = 0;
      mDecB = 0;
      qA.delete();
      qB.delete();
   endfunction

   // Behavioural model: rectify, then apply the attack/hold/release rules directly.
   function automatic void modelSample(input logic [31:0] s, input int due);
      longint a;
      longint step;
      exp_t   e;
      if (s == 32'h8000_0000) a = 64'd2147483647;
      else if ($signed(s) < 0) a = -longint'($signed(s));
      else a = longint'($signed(s));
      if (a > mEnv) begin
         step = (a - mEnv) >>> AS;
         if (step < 1) step = 1;
         mEnv  = mEnv + step;
         mHold = HOLDN;
      end else if (mHold != 0) begin
         mHold = mHold - 1;
      end else if (mEnv > a) begin
         step = (mEnv - a) >>> RS;
         if (step < 1) step = 1;
         mEnv = mEnv - step;
      end
      e.env = mEnv;
      e.due = due;
      qA.push_back(e);
      mDecB++;
      if (mDecB == DECB) begin
         mDecB = 0;
         qB.push_back(e);
      end
   endfunction

   // Called at posedge+1; drives one sample for exactly one capture edge.
   task automatic applyStimulus(input logic [31:0] s);
      valid_in  = 1'b1;
      sample_in = s;
      modelSample(s, cyc + 2);
      @(posedge clk_in);
      #1;
      valid_in = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clk_in);
         #1;
      end
   endtask

   task automatic doReset();
      rst_n_in = 1'b0;
      valid_in = 1'b0;
      modelReset();
      idle(2);
      rst_n_in = 1'b1;
      idle(1);
   endtask

   always @(negedge clk_in) begin
      if (rst_n_in) begin
         if (validA) begin
            if (qA.size() == 0) begin
               checkOutput("unexpectedA", 1, 0);
            end else begin
               eA = qA.pop_front();
               checkOutput("envA", longint'(envA), eA.env);
               checkOutput("latencyA", cyc, eA.due);
            end
         end
         if (validB) begin
            pulsesB++;
            if (qB.size() == 0) begin
               checkOutput("unexpectedB", 1, 0);
            end else begin
               eB = qB.pop_front();
               checkOutput("envB", longint'(envB), eB.env);
               checkOutput("latencyB", cyc, eB.due);
            end
         end
      end
   end

   initial begin
      logic [31:0] s;
      int          cat;

      // Held in reset with traffic on the inputs: outputs stay cleared.
      rst_n_in = 1'b0;
      for (int i = 0; i < 6; i++) begin
         valid_in  = 1'($urandom_range(0, 1));
         sample_in = $urandom;
         @(negedge clk_in);
         checkOutput("rstEnvA", longint'(envA), 0);
         checkOutput("rstValidA", longint'(validA), 0);
         checkOutput("rstEnvB", longint'(envB), 0);
         checkOutput("rstValidB", longint'(validB), 0);
      end
      @(posedge clk_in);
      #1;
      valid_in = 1'b0;
      modelReset();
      rst_n_in = 1'b1;
      idle(1);

      // Attack toward 1000, then hold and release toward 0.
      for (int i = 0; i < 40; i++) applyStimulus(32'd1000);
      idle(3);
      checkOutput("attackSettled", longint'(envA), 1000);
      for (int i = 0; i < 160; i++) applyStimulus(32'd0);
      idle(3);
      checkOutput("releaseSettled", longint'(envA), 0);

      // Negative input attacks exactly like its magnitude.
      for (int i = 0; i < 10; i++) applyStimulus(32'hFFFF_FC18);
      idle(3);

      // Asynchronous clear between clock edges.
      #2;
      rst_n_in = 1'b0;
      #1;
      checkOutput("asyncEnvA", longint'(envA), 0);
      checkOutput("asyncEnvB", longint'(envB), 0);
      valid_in = 1'b0;
      modelReset();
      @(posedge clk_in);
      #1;
      rst_n_in = 1'b1;
      idle(1);

      // Saturating rectification of the most negative sample.
      applyStimulus(32'h8000_0000);
      idle(3);
      checkOutput("satFirst", longint'(envA), 536870911);

      // Minimum-step release from 3 down to 0 with no underflow.
      doReset();
      for (int i = 0; i < 3; i++) applyStimulus(32'd3);
      for (int i = 0; i < 8; i++) applyStimulus(32'd0);
      idle(3);
      checkOutput("minStepFloor", longint'(envA), 0);

      // Decimation across twelve back-to-back samples.
      doReset();
      pulsesB = 0;
      for (int i = 0; i < 12; i++) applyStimulus(32'd5000 + 32'(i * 100));
      idle(4);
      checkOutput("decimPulses", pulsesB, 3);

      // Reset mid-window restarts the decimation count.
      doReset();
      pulsesB = 0;
      for (int i = 0; i < 6; i++) applyStimulus(32'd700);
      checkOutput("preResetPulses", pulsesB, 1);
      doReset();
      pulsesB = 0;
      for (int i = 0; i < 3; i++) applyStimulus(32'd700);
      idle(5);
      checkOutput("freshWindowNone", pulsesB, 0);
      applyStimulus(32'd700);
      idle(4);
      checkOutput("freshWindowOne", pulsesB, 1);

      // Randomized traffic with random gaps and magnitudes.
      doReset();
      for (int i = 0; i < 400; i++) begin
         cat = int'($urandom_range(0, 9));
         if (cat < 5) s = 32'($signed($urandom_range(0, 4000)) - 2000);
         else if (cat < 7) s = $urandom;
         else if (cat == 7) s = 32'h8000_0000;
         else s = 32'd0;
         applyStimulus(s);
         if ($urandom_range(0, 3) == 0) idle(int'($urandom_range(1, 3)));
      end
      idle(6);
      checkOutput("drainA", qA.size(), 0);
      checkOutput("drainB", qB.size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/envelope_follower.md
# envelope_follower

Consumes the band-filtered sample stream produced by the cascaded biquad filters and turns each band into a smoothed amplitude envelope for the vocoder's gain stage. Full-wave rectifies each sample, tracks it with separate attack and release slew rates plus a hold period, and emits the envelope decimated by a fixed factor. One instance per analysis band, fed directly from the filter's `sample_out`/`valid_out`.

## Interface
- `ATTACK_SHIFT`, 4: attack smoothing; rising step is `(abs - env) >> ATTACK_SHIFT`.
- `RELEASE_SHIFT`, 10: release smoothing; falling step is `(env - abs) >> RELEASE_SHIFT`.
- `HOLD_SAMPLES`, 64: accepted samples the envelope is frozen after the last attack before release begins; range 0..2^16-1.
- `DECIM`, 32: one output per `DECIM` accepted samples; range 1..2^16.
- `clk_in`  input  1  system clock.
- `rst_n_in`  input  1  reset. One clock; reset is asynchronous and active-low.
- `valid_in`  input  1  one-cycle strobe, `sample_in` valid; may be asserted every cycle.
- `sample_in`  input  32  signed band sample.
- `env_out`  output  32  unsigned envelope, range 0..2^31-1; held between strobes.
- `valid_out`  output  1  one-cycle strobe, `env_out` updated.

## Operation
- Stage 1, on `valid_in`: register `abs = |sample_in|`, saturated: -2^31 maps to 2^31-1.
- Stage 2, on the stage-1 valid: phase FSM with states ATTACK, HOLD, RELEASE, plus 32-bit `env`.
  - If `abs > env`: `env += max((abs-env)>>ATTACK_SHIFT, 1)`. Reload `hold_cnt = HOLD_SAMPLES`. Phase goes to ATTACK.
  - Else if `hold_cnt != 0`: decrement `hold_cnt`. `env` is unchanged. Phase goes to HOLD.
  - Else if `env > abs`: `env -= max((env-abs)>>RELEASE_SHIFT, 1)`. Phase goes to RELEASE.
  - Else (`abs == env`): no change.
- Minimum step of 1 guarantees convergence to exactly `abs`.
- Never overshoot in either direction: `env` stays between its old value and `abs`.
- All differences are computed unsigned on 32 bits; no overflow is possible, since both operands are ≤ 2^31-1.
- Decimation counter `dec_cnt` (0..DECIM-1) advances on every stage-2 update.
  - When it wraps from DECIM-1 to 0, the updated `env` is copied into `env_out` and `valid_out` pulses.
  - `DECIM=1`: every sample produces an output.
- Samples are never dropped. Back-to-back `valid_in` is processed at full rate.

## Timing
- Latency: `valid_in` in cycle N, then stage-1 register in N+1, then `env`/`env_out`/`valid_out` registered in N+2.
- `valid_out` is high for exactly one cycle per emitted envelope. It is never high on two consecutive cycles unless `DECIM=1` and `valid_in` is continuous.
- Reset values (async on `rst_n_in` low): `env_out=0`, `valid_out=0`, `env=0`, `hold_cnt=0`, `dec_cnt=0`, phase=RELEASE, stage-1 valid=0.
- Reset asserted mid-stream: in-flight samples are discarded. The first `valid_in` after release of reset is treated as sample 0 of a fresh decimation window.
- `HOLD_SAMPLES=0`: release begins on the first non-attack sample.

## Structure
- Package `envelope_pkg`:
  - `typedef enum logic [1:0] {ATTACK, HOLD, RELEASE} env_phase_e`
  - `ENV_MAX = 32'h7FFF_FFFF`
  - `function sat_abs` (32-bit signed to 32-bit unsigned, saturating).
- One sub-module, `env_slew`, is natural. It takes `env`, `abs` and a shift amount, and returns the stepped value with the min-1 and no-overshoot rules. It is instantiated twice (attack and release), so the top level contains only the FSM, the counters and the pipeline.

## Test plan
All scenarios use `ATTACK_SHIFT=2`, `RELEASE_SHIFT=4`, `HOLD_SAMPLES=2`, `DECIM=1` unless stated otherwise.
- Reset: hold `rst_n_in` low, toggle `valid_in` with random samples → `env_out=0` and `valid_out=0` throughout. Check also that the reset assertion asynchronously clears outputs between clock edges.
- Attack: constant `sample_in=1000`, one per cycle → `env_out` sequence 250, 437, 577, 682, ... converging to exactly 1000. Each `valid_out` appears 2 cycles after its `valid_in`.
- Saturation: `sample_in=-2^31` from `env=0` → first `env_out=536870911`. With `sample_in=-1000`, behaviour is identical to the +1000 case.
- Hold then release: converge `env` to 1000, then drive `sample_in=0` → outputs 1000, 1000, then 938, 880, ....
- Min step: settle `env=3`, hold expired, drive 0 → outputs 2, 1, 0, 0 (no underflow).
- Decimation and reset mid-stream: `DECIM=4`, 12 back-to-back samples → exactly 3 `valid_out` pulses, at cycles 5, 9 and 13 relative to the first `valid_in`. Asserting `rst_n_in` after sample 6 yields no further pulse until 4 new samples arrive.
